instruction_fetch_unit: RTL and testbench

//  Fetch stage that drives the word-addressed instruction memory and owns the PC.

---
 rtl/instruction_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch stage. Owns the PC, drives a word-addressed instruction
//               memory and hands each fetched word to decode through a
//               one-entry IF/ID register with a valid/ready handshake.
//               J/JAL are resolved here with no bubble, redirects from later
//               stages (branch, jr) take top priority, syscall halts fetch
//               and an illegal PC (misaligned or beyond memory) faults.
// Ports       : clk_i, reset_i        clock / async active-high reset
//               imem_addr_o           byte address to memory (= pc)
//               imem_instr_i          instruction word for imem_addr_o
//               id_valid_o/id_ready_i IF/ID handshake
//               id_instr_o, id_pc_o, id_pc_plus4_o  IF/ID payload
//               redirect_valid_i, redirect_target_i  PC override
//               halted_o, fault_o, fault_pc_o        terminal status
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          MEM_DEPTH      = 256,
    parameter bit          JUMP_PREDECODE = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_plus4_o,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    output logic        halted_o,
    output logic        fault_o,
    output logic [31:0] fault_pc_o
);

    localparam logic [31:0] PC_LIMIT    = 32'(MEM_DEPTH * 4);
    localparam logic [5:0]  OP_J        = 6'h02;
    localparam logic [5:0]  OP_JAL      = 6'h03;
    localparam logic [31:0] SYSCALL_OP  = 32'h0000_000C;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    logic        can_load;
    logic        pc_bad;
    logic        is_jump;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;
    assign can_load = !id_valid_q || id_ready_i;
    assign pc_bad   = (pc_q[1:0] != 2'b00) || (pc_q >= PC_LIMIT);
    assign is_jump  = JUMP_PREDECODE &&
                      ((imem_instr_i[31:26] == OP_J) || (imem_instr_i[31:26] == OP_JAL));

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        halted_d      = halted_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;

        // Outside of a capture the pending entry simply drains on handshake.
        if (id_valid_q && id_ready_i) begin
            id_valid_d = 1'b0;
        end

        if (state_q == ST_RUN) begin
            if (redirect_valid_i) begin
                pc_d       = redirect_target_i;
                id_valid_d = 1'b0;
            end else if (pc_bad) begin
                state_d    = ST_FAULT;
                fault_d    = 1'b1;
                fault_pc_d = pc_q;
            end else if (can_load) begin
                id_instr_d    = imem_instr_i;
                id_pc_d       = pc_q;
                id_pc_plus4_d = pc_plus4;
                id_valid_d    = 1'b1;
                if (is_jump) begin
                    // JAL still goes to decode so the link register is written.
                    pc_d = {pc_plus4[31:28], imem_instr_i[25:0], 2'b00};
                end else if (imem_instr_i == SYSCALL_OP) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else begin
                    pc_d = pc_plus4;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'd0;
            id_pc_q       <= 32'd0;
            id_pc_plus4_q <= 32'd0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            fault_pc_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign id_valid_o    = id_valid_q;
    assign id_instr_o    = id_instr_q;
    assign id_pc_o       = id_pc_q;
    assign id_pc_plus4_o = id_pc_plus4_q;
    assign halted_o      = halted_q;
    assign fault_o       = fault_q;
    assign fault_pc_o    = fault_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed bench for instruction_fetch_unit with a behavioural
//               combinational instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halted;
    logic        fault;
    logic [31:0] fault_pc;

    logic [31:0] mem [0:255];

    int n_vec;
    int n_err;

    instruction_fetch_unit #(
        .RESET_PC       (32'h0000_0000),
        .MEM_DEPTH      (256),
        .JUMP_PREDECODE (1'b1)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .imem_addr_o       (imem_addr),
        .imem_instr_i      (imem_instr),
        .id_valid_o        (id_valid),
        .id_ready_i        (id_ready),
        .id_instr_o        (id_instr),
        .id_pc_o           (id_pc),
        .id_pc_plus4_o     (id_pc_plus4),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .halted_o          (halted),
        .fault_o           (fault),
        .fault_pc_o        (fault_pc)
    );

    assign imem_instr = mem[imem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
        mem[0]  = 32'h8C10_0000;
        mem[1]  = 32'h8C12_0004;
        mem[2]  = 32'h0C00_000C;   // JAL -> 0x30
        mem[19] = 32'h0000_000C;   // syscall at 0x4C

        reset           = 1'b1;
        id_ready        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        #3;

        // Reset state
        chk("rst_valid",    32'(id_valid), 32'd0);
        chk("rst_addr",     imem_addr,     32'h0);
        chk("rst_id_pc",    id_pc,         32'h0);
        chk("rst_instr",    id_instr,      32'h0);
        chk("rst_halted",   32'(halted),   32'd0);
        chk("rst_fault",    32'(fault),    32'd0);
        chk("rst_fault_pc", fault_pc,      32'h0);

        // 1. Straight-line fetch into JAL with no bubble
        @(posedge clk); #1;
        reset = 1'b0;
        tick();
        chk("t1_pc0",      id_pc,          32'h00);
        chk("t1_valid0",   32'(id_valid),  32'd1);
        chk("t1_instr0",   id_instr,       32'h8C10_0000);
        chk("t1_addr0",    imem_addr,      32'h04);
        tick();
        chk("t1_pc1",      id_pc,          32'h04);
        tick();
        chk("t1_pc2",      id_pc,          32'h08);
        chk("t1_instr2",   id_instr,       32'h0C00_000C);
        chk("t1_plus4",    id_pc_plus4,    32'h0C);
        chk("t1_jaddr",    imem_addr,      32'h30);
        tick();
        chk("t1_pc_tgt",   id_pc,          32'h30);
        chk("t1_valid3",   32'(id_valid),  32'd1);

        // 2. Stall while id_pc=0x04
        pulse_reset();
        tick();
        tick();
        chk("t2_pc1",      id_pc,          32'h04);
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2_st_instr", id_instr,      32'h8C12_0004);
            chk("t2_st_pc",    id_pc,         32'h04);
            chk("t2_st_addr",  imem_addr,     32'h08);
            chk("t2_st_valid", 32'(id_valid), 32'd1);
        end
        id_ready = 1'b1;
        tick();
        chk("t2_resume",   id_pc,          32'h08);

        // 3. Redirect in the same cycle as a stall
        id_ready        = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h34;
        tick();
        chk("t3_flush",    32'(id_valid),  32'd0);
        chk("t3_addr",     imem_addr,      32'h34);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        tick();
        chk("t3_pc",       id_pc,          32'h34);
        chk("t3_valid",    32'(id_valid),  32'd1);

        // 4. Run to syscall at 0x4C
        for (int k = 0; k < 6; k++) tick();
        chk("t4_pc",       id_pc,          32'h4C);
        chk("t4_instr",    id_instr,       32'h0000_000C);
        chk("t4_halted",   32'(halted),    32'd1);
        chk("t4_addr",     imem_addr,      32'h4C);
        id_ready = 1'b0;
        tick();
        tick();
        chk("t4_hold_v",   32'(id_valid),  32'd1);
        chk("t4_hold_a",   imem_addr,      32'h4C);
        id_ready        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h00;
        tick();
        chk("t4_drain",    32'(id_valid),  32'd0);
        chk("t4_ignore",   imem_addr,      32'h4C);
        tick();
        chk("t4_still_h",  32'(halted),    32'd1);
        chk("t4_no_cap",   32'(id_valid),  32'd0);
        redirect_valid = 1'b0;

        // 5. Misaligned and out-of-range redirect targets
        pulse_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0402;
        tick();
        redirect_valid = 1'b0;
        chk("t5_addr",     imem_addr,      32'h402);
        tick();
        chk("t5_fault",    32'(fault),     32'd1);
        chk("t5_fpc",      fault_pc,       32'h402);
        chk("t5_valid",    32'(id_valid),  32'd0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h10;
        tick();
        chk("t5_ignore",   imem_addr,      32'h402);
        redirect_valid = 1'b0;

        pulse_reset();
        chk("t5_rst_flt",  32'(fault),     32'd0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0400;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("t5_fault2",   32'(fault),     32'd1);
        chk("t5_fpc2",     fault_pc,       32'h400);
        chk("t5_valid2",   32'(id_valid),  32'd0);

        // Last legal word: 0x3FC must fetch, not fault
        pulse_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'h3FC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("t5_edge_f",   32'(fault),     32'd0);
        chk("t5_edge_pc",  id_pc,          32'h3FC);
        chk("t5_wrap",     imem_addr,      32'h400);

        // 6. Async reset during a stall
        pulse_reset();
        tick();
        id_ready = 1'b0;
        tick();
        chk("t6_pre_v",    32'(id_valid),  32'd1);
        chk("t6_pre_a",    imem_addr,      32'h04);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_v",  32'(id_valid),  32'd0);
        chk("t6_async_a",  imem_addr,      32'h00);
        chk("t6_async_p",  id_pc,          32'h00);
        #1;
        reset    = 1'b0;
        id_ready = 1'b1;
        tick();
        chk("t6_resume0",  id_pc,          32'h00);
        chk("t6_resume_v", 32'(id_valid),  32'd1);
        tick();
        chk("t6_resume1",  id_pc,          32'h04);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
